vedic_mac_accum: RTL

- Downstream consumer of the 32x32 Vedic multiplier's registered 64-bit product stream.
- Accumulates a packet of unsigned products, delimited by prod_last, into a wide sum (dot-product / MAC stage).
- Presents the sum, term count and overflow flag on a valid/ready output. Holds the result under backpressure.
- Upstream control generates prod_valid/prod_last aligned to the multiplier's 2-cycle latency.

---
 rtl/vedic_mac_accum.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vedic_mac_accum.sv
// Packet accumulator for the Vedic multiplier's 64-bit product stream.
// Sums unsigned products until prod_last, then holds {sum, count, overflow} on a valid/ready port.
module vedic_mac_accum #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 80,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_last,
    output logic              prod_ready,
    output logic              sum_valid,
    output logic [ACC_W-1:0]  sum_data,
    output logic [CNT_W-1:0]  sum_count,
    output logic              sum_ovf,
    input  logic              sum_ready
);

    // state | meaning
    // IDLE  | no beats yet; acc, cnt and ovf are zero
    // ACCUM | at least one beat taken, last not yet seen
    // HOLD  | result presented, waiting for sum_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               prod_ready_q, prod_ready_d;
    logic               sum_valid_q, sum_valid_d;
    logic [ACC_W-1:0]   sum_data_q, sum_data_d;
    logic [CNT_W-1:0]   sum_count_q, sum_count_d;
    logic               sum_ovf_q, sum_ovf_d;

    logic               beat_acc;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W:0]     add_w;
    logic [CNT_W-1:0]   cnt_inc;

    assign beat_acc = prod_valid && prod_ready_q;
    assign prod_ext = ACC_W'(prod_data);
    // Extra MSB captures the carry-out that feeds the sticky overflow flag.
    assign add_w    = {1'b0, acc_q} + {1'b0, prod_ext};
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            sum_valid_q  <= 1'b0;
            sum_data_q   <= '0;
            sum_count_q  <= '0;
            sum_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            prod_ready_q <= prod_ready_d;
            sum_valid_q  <= sum_valid_d;
            sum_data_q   <= sum_data_d;
            sum_count_q  <= sum_count_d;
            sum_ovf_q    <= sum_ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        prod_ready_d = prod_ready_q;
        sum_valid_d  = sum_valid_q;
        sum_data_d   = sum_data_q;
        sum_count_d  = sum_count_q;
        sum_ovf_d    = sum_ovf_q;

        if (clr) begin
            // Abort: drop any partial or pending result; last sum_* payload is kept.
            state_d      = IDLE;
            acc_d        = '0;
            cnt_d        = '0;
            ovf_d        = 1'b0;
            sum_valid_d  = 1'b0;
            prod_ready_d = 1'b1;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    prod_ready_d = 1'b1;
                    if (beat_acc) begin
                        if (prod_last) begin
                            sum_data_d   = add_w[ACC_W-1:0];
                            sum_count_d  = cnt_inc;
                            sum_ovf_d    = ovf_q | add_w[ACC_W];
                            sum_valid_d  = 1'b1;
                            prod_ready_d = 1'b0;
                            state_d      = HOLD;
                        end else begin
                            acc_d   = add_w[ACC_W-1:0];
                            cnt_d   = cnt_inc;
                            ovf_d   = ovf_q | add_w[ACC_W];
                            state_d = ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (sum_ready) begin
                        sum_valid_d  = 1'b0;
                        acc_d        = '0;
                        cnt_d        = '0;
                        ovf_d        = 1'b0;
                        prod_ready_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign prod_ready = prod_ready_q;
    assign sum_valid  = sum_valid_q;
    assign sum_data   = sum_data_q;
    assign sum_count  = sum_count_q;
    assign sum_ovf    = sum_ovf_q;

endmodule
